// File: rtl/glitch_gen_pkg.sv
// Shared types and defaults for the multi-channel glitch generator.
// Holds the per-channel state encoding, default parameter values and the
// helper that promotes zero-valued width/gap/count fields to one.
package glitch_gen_pkg;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_BURST_W     = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } ch_state_e;

    // A zero width, gap or count would stall the down-counters, so it is
    // treated as one. Callers size the result back to their field width.
    function automatic logic [63:0] min_one(input logic [63:0] v);
        return (v == 64'd0) ? 64'd1 : v;
    endfunction

endpackage

// File: rtl/glitch_channel.sv
// One glitch channel: shadow configuration, a shared delay/width/gap
// down-counter, a remaining-pulse counter and the sequencing FSM.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   trig_rise_i          one-cycle synchronised trigger rising edge
//   abort_i              synchronised abort, returns the channel to IDLE
//   arm_i                arm strobe, latches cfg_*_i in IDLE/ARMED/DONE
//   cfg_*_i              delay, width, gap, count, polarity
//   glitch_o             registered glitch level (polarity applied)
//   armed_o/busy_o/done_o status
//
// state  | meaning
// IDLE   | not armed, output inactive
// ARMED  | config latched, waiting for trig_rise
// DELAY  | counting down delay before the first pulse
// PULSE  | output active, counting down width
// GAP    | output inactive between burst pulses
// DONE   | burst complete, done held until the next arm
module glitch_channel
    import glitch_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trig_rise_i,
    input  logic               abort_i,
    input  logic               arm_i,
    input  logic [CNT_W-1:0]   cfg_delay_i,
    input  logic [CNT_W-1:0]   cfg_width_i,
    input  logic [CNT_W-1:0]   cfg_gap_i,
    input  logic [BURST_W-1:0] cfg_count_i,
    input  logic               cfg_pol_i,
    output logic               glitch_o,
    output logic               armed_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    ch_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] pulses_q, pulses_d;
    logic [CNT_W-1:0]   delay_q, delay_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic               pol_q, pol_d;
    logic               done_q, done_d;
    logic               act_q, act_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulses_d = pulses_q;
        delay_d  = delay_q;
        width_d  = width_q;
        gap_d    = gap_q;
        count_d  = count_q;
        pol_d    = pol_q;
        done_d   = done_q;

        if (abort_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ARMED: begin
                    // In ARMED a trigger beats a coincident arm.
                    if (state_q == ST_ARMED && trig_rise_i) begin
                        pulses_d = count_q;
                        if (delay_q == '0) begin
                            state_d = ST_PULSE;
                            cnt_d   = width_q;
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = delay_q;
                        end
                    end else if (arm_i) begin
                        delay_d = cfg_delay_i;
                        width_d = CNT_W'(min_one(64'(cfg_width_i)));
                        gap_d   = CNT_W'(min_one(64'(cfg_gap_i)));
                        count_d = BURST_W'(min_one(64'(cfg_count_i)));
                        pol_d   = cfg_pol_i;
                        done_d  = 1'b0;
                        state_d = ST_ARMED;
                    end
                end
                ST_DELAY, ST_GAP: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_PULSE;
                        cnt_d   = width_q;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q != CNT_ONE) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (pulses_q == BURST_ONE) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_GAP;
                        cnt_d    = gap_q;
                        pulses_d = pulses_q - BURST_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        act_d = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pulses_q <= '0;
            delay_q  <= '0;
            width_q  <= CNT_ONE;
            gap_q    <= CNT_ONE;
            count_q  <= BURST_ONE;
            pol_q    <= 1'b0;
            done_q   <= 1'b0;
            act_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulses_q <= pulses_d;
            delay_q  <= delay_d;
            width_q  <= width_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            pol_q    <= pol_d;
            done_q   <= done_d;
            act_q    <= act_d;
        end
    end

    // In IDLE no polarity has been latched yet, so the live setting defines
    // the inactive level; act_q is 0 there, so the output stays quiet.
    assign glitch_o = act_q ^ ((state_q == ST_IDLE) ? cfg_pol_i : pol_q);
    assign armed_o  = (state_q == ST_ARMED);
    assign busy_o   = (state_q == ST_DELAY) || (state_q == ST_PULSE) || (state_q == ST_GAP);
    assign done_o   = done_q;

endmodule

// File: rtl/glitch_gen_multi.sv
// Multi-channel glitch generator top level.
// Synchronises trigger and abort, derives a one-cycle trigger rising edge
// and fans both out to NUM_CH independent glitch_channel instances.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   trigger, abort   asynchronous inputs
//   arm              per-channel arm strobes
//   cfg_*            packed per-channel configuration, channel i at slice i
//   glitch           per-channel glitch outputs
//   armed/busy/done  per-channel status
module glitch_gen_multi
    import glitch_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned BURST_W     = DEF_BURST_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      trigger,
    input  logic [NUM_CH-1:0]         arm,
    input  logic                      abort,
    input  logic [NUM_CH*CNT_W-1:0]   cfg_delay,
    input  logic [NUM_CH*CNT_W-1:0]   cfg_width,
    input  logic [NUM_CH*CNT_W-1:0]   cfg_gap,
    input  logic [NUM_CH*BURST_W-1:0] cfg_count,
    input  logic [NUM_CH-1:0]         cfg_pol,
    output logic [NUM_CH-1:0]         glitch,
    output logic [NUM_CH-1:0]         armed,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done
);

    logic [SYNC_STAGES-1:0] trig_sync_q;
    logic [SYNC_STAGES-1:0] abort_sync_q;
    logic                   trig_prev_q;
    logic                   trig_rise_q;
    logic                   trig_s;
    logic                   abort_s;

    assign trig_s  = trig_sync_q[SYNC_STAGES-1];
    assign abort_s = abort_sync_q[SYNC_STAGES-1];

    // trig_rise is registered so that the first active cycle lands exactly
    // SYNC_STAGES+1+delay edges after the first edge that sees the trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_sync_q  <= '0;
            abort_sync_q <= '0;
            trig_prev_q  <= 1'b0;
            trig_rise_q  <= 1'b0;
        end else begin
            trig_sync_q  <= {trig_sync_q[SYNC_STAGES-2:0], trigger};
            abort_sync_q <= {abort_sync_q[SYNC_STAGES-2:0], abort};
            trig_prev_q  <= trig_s;
            trig_rise_q  <= trig_s & ~trig_prev_q;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        glitch_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .trig_rise_i (trig_rise_q),
            .abort_i     (abort_s),
            .arm_i       (arm[i]),
            .cfg_delay_i (cfg_delay[i*CNT_W +: CNT_W]),
            .cfg_width_i (cfg_width[i*CNT_W +: CNT_W]),
            .cfg_gap_i   (cfg_gap[i*CNT_W +: CNT_W]),
            .cfg_count_i (cfg_count[i*BURST_W +: BURST_W]),
            .cfg_pol_i   (cfg_pol[i]),
            .glitch_o    (glitch[i]),
            .armed_o     (armed[i]),
            .busy_o      (busy[i]),
            .done_o      (done[i])
        );
    end

endmodule

// File: tb/tb_glitch_gen_multi.sv
module tb_glitch_gen_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 32;
    localparam int BURST_W = 8;
    localparam int SYNC    = 2;
    localparam logic [NUM_CH-1:0] POL = 4'b0100;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      trigger;
    logic                      abort;
    logic [NUM_CH-1:0]         arm;
    logic [NUM_CH*CNT_W-1:0]   cfg_delay;
    logic [NUM_CH*CNT_W-1:0]   cfg_width;
    logic [NUM_CH*CNT_W-1:0]   cfg_gap;
    logic [NUM_CH*BURST_W-1:0] cfg_count;
    logic [NUM_CH-1:0]         cfg_pol;
    logic [NUM_CH-1:0]         glitch;
    logic [NUM_CH-1:0]         armed;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         done;

    int checks   = 0;
    int failures = 0;

    // Per-cycle {armed, busy, done, glitch} of the channel under test.
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    always #5 clk = ~clk;

    glitch_gen_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .BURST_W     (BURST_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (trigger),
        .arm       (arm),
        .abort     (abort),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_gap   (cfg_gap),
        .cfg_count (cfg_count),
        .cfg_pol   (cfg_pol),
        .glitch    (glitch),
        .armed     (armed),
        .busy      (busy),
        .done      (done)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_cfg(input int ch, input int d, input int w, input int g, input int c);
        cfg_delay[ch*CNT_W +: CNT_W]     = CNT_W'(d);
        cfg_width[ch*CNT_W +: CNT_W]     = CNT_W'(w);
        cfg_gap[ch*CNT_W +: CNT_W]       = CNT_W'(g);
        cfg_count[ch*BURST_W +: BURST_W] = BURST_W'(c);
    endtask

    task automatic do_arm(input int ch);
        arm[ch] = 1'b1;
        step();
        arm[ch] = 1'b0;
    endtask

    // Raises trigger, then samples n cycles; step j is the sample after edge
    // k+j where edge k is the first to see trigger high. Expectations come
    // from the timing model; stimulus actions happen after the sample of step j.
    task automatic run_burst(input int ch, input int n, input int d, input int w,
                             input int g, input int c, input logic pol,
                             input int lo_at, input int hi_at, input int abort_at,
                             input int arm_at);
        int wn, gn, cn, start, stop, p;
        logic act, bsy, dn, arm_e;
        wn = (w == 0) ? 1 : w;
        gn = (g == 0) ? 1 : g;
        cn = (c == 0) ? 1 : c;
        start = SYNC + 1 + d;
        stop  = start + cn * wn + (cn - 1) * gn;
        for (int j = 0; j < n; j++) begin
            act = 1'b0;
            if (j >= start && j < stop) begin
                p   = (j - start) % (wn + gn);
                act = (p < wn);
            end
            bsy   = (j >= SYNC + 1) && (j < stop);
            dn    = (j >= stop);
            arm_e = (j < SYNC + 1);
            if (abort_at >= 0 && j >= abort_at + SYNC + 1) begin
                act = 1'b0; bsy = 1'b0; dn = 1'b0; arm_e = 1'b0;
            end
            exp_q.push_back({arm_e, bsy, dn, act ^ pol});
        end
        trigger = 1'b1;
        for (int j = 0; j < n; j++) begin
            step();
            obs_q.push_back({armed[ch], busy[ch], done[ch], glitch[ch]});
            arm[ch] = (j == arm_at);
            if (j == lo_at)    trigger = 1'b0;
            if (j == hi_at)    trigger = 1'b1;
            if (j == abort_at) abort = 1'b1;
        end
        trigger = 1'b0;
        abort   = 1'b0;
        arm     = '0;
        idle(SYNC + 2);
    endtask

    task automatic test_reset();
        idle(2);
        checks++; if (glitch !== POL) begin failures++; $display("FAIL reset_glitch got %b expected %b", glitch, POL); end
        checks++; if (armed !== 4'b0) begin failures++; $display("FAIL reset_armed got %b expected 0000", armed); end
        checks++; if (busy !== 4'b0) begin failures++; $display("FAIL reset_busy got %b expected 0000", busy); end
        checks++; if (done !== 4'b0) begin failures++; $display("FAIL reset_done got %b expected 0000", done); end
        rst_n = 1'b1;
        idle(3);
        checks++; if (glitch !== POL) begin failures++; $display("FAIL release_glitch got %b expected %b", glitch, POL); end
    endtask

    task automatic test_single();
        logic [3:0] e, o;
        int j;
        set_cfg(0, 10, 3, 0, 1);
        do_arm(0);
        checks++; if (armed[0] !== 1'b1) begin failures++; $display("FAIL single_armed got %b expected 1", armed[0]); end
        run_burst(0, 22, 10, 3, 0, 1, 1'b0, -1, -1, -1, -1);
        j = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL single ch0 step %0d got %b expected %b (armed,busy,done,glitch)", j, o, e); end
            j++;
        end
    endtask

    task automatic test_burst();
        logic [3:0] e, o;
        int j;
        set_cfg(1, 0, 2, 4, 3);
        do_arm(1);
        run_burst(1, 22, 0, 2, 4, 3, 1'b0, -1, -1, -1, -1);
        j = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL burst ch1 step %0d got %b expected %b (armed,busy,done,glitch)", j, o, e); end
            j++;
        end
    endtask

    task automatic test_polarity();
        logic [3:0] e, o;
        int j;
        checks++; if (glitch[2] !== 1'b1) begin failures++; $display("FAIL pol_idle got %b expected 1", glitch[2]); end
        set_cfg(2, 4, 0, 0, 1);
        do_arm(2);
        run_burst(2, 12, 4, 0, 0, 1, 1'b1, -1, -1, -1, -1);
        j = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL polarity ch2 step %0d got %b expected %b (armed,busy,done,glitch)", j, o, e); end
            j++;
        end
    endtask

    task automatic test_retrigger();
        logic [3:0] e, o;
        int j, highs;
        // Trigger after DONE: nothing happens, done stays set.
        highs = 0;
        trigger = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (glitch[0] || busy[0]) highs++;
        end
        trigger = 1'b0;
        idle(SYNC + 2);
        checks++; if (highs !== 0) begin failures++; $display("FAIL done_retrig_activity got %0d expected 0", highs); end
        checks++; if (done[0] !== 1'b1) begin failures++; $display("FAIL done_sticky got %b expected 1", done[0]); end
        set_cfg(0, 10, 3, 0, 1);
        do_arm(0);
        checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL rearm_done_clear got %b expected 0", done[0]); end
        checks++; if (armed[0] !== 1'b1) begin failures++; $display("FAIL rearm_armed got %b expected 1", armed[0]); end
        // Second trigger edge arrives while the channel is in DELAY.
        run_burst(0, 22, 10, 3, 0, 1, 1'b0, 3, 5, -1, -1);
        j = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL retrigger ch0 step %0d got %b expected %b (armed,busy,done,glitch)", j, o, e); end
            j++;
        end
    endtask

    task automatic test_arm_vs_trigger();
        logic [3:0] e, o;
        int j;
        set_cfg(1, 1, 2, 1, 1);
        do_arm(1);
        // New config on the bus must not be taken by the coincident arm.
        set_cfg(1, 20, 5, 5, 2);
        run_burst(1, 12, 1, 2, 1, 1, 1'b0, -1, -1, -1, 2);
        j = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL arm_vs_trig ch1 step %0d got %b expected %b (armed,busy,done,glitch)", j, o, e); end
            j++;
        end
    endtask

    task automatic test_abort();
        logic [3:0] e, o;
        int j;
        set_cfg(3, 2, 100, 0, 1);
        do_arm(3);
        run_burst(3, 16, 2, 100, 0, 1, 1'b0, -1, -1, 10, -1);
        j = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL abort ch3 step %0d got %b expected %b (armed,busy,done,glitch)", j, o, e); end
            j++;
        end
        abort = 1'b1;
        idle(SYNC + 2);
        set_cfg(3, 2, 3, 0, 1);
        do_arm(3);
        step();
        checks++; if (armed !== 4'b0) begin failures++; $display("FAIL abort_held_arm got %b expected 0000", armed); end
        checks++; if (done !== 4'b0) begin failures++; $display("FAIL abort_done_all got %b expected 0000", done); end
        checks++; if (glitch !== POL) begin failures++; $display("FAIL abort_glitch_all got %b expected %b", glitch, POL); end
        abort = 1'b0;
        idle(SYNC + 2);
    endtask

    task automatic test_async_reset();
        set_cfg(1, 0, 2, 4, 3);
        do_arm(1);
        trigger = 1'b1;
        idle(SYNC + 2);
        checks++; if (glitch[1] !== 1'b1) begin failures++; $display("FAIL pre_reset_pulse got %b expected 1", glitch[1]); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (glitch !== POL) begin failures++; $display("FAIL async_rst_glitch got %b expected %b", glitch, POL); end
        checks++; if (busy !== 4'b0) begin failures++; $display("FAIL async_rst_busy got %b expected 0000", busy); end
        checks++; if ({armed, done} !== 8'b0) begin failures++; $display("FAIL async_rst_armed_done got %b expected 00000000", {armed, done}); end
        step();
        trigger = 1'b0;
        rst_n   = 1'b1;
        idle(SYNC + 2);
        checks++; if (glitch !== POL) begin failures++; $display("FAIL post_reset_glitch got %b expected %b", glitch, POL); end
    endtask

    task automatic test_arm_trig_idle();
        int highs;
        set_cfg(0, 0, 3, 0, 1);
        trigger = 1'b1;
        idle(SYNC + 1);
        arm[0] = 1'b1;
        step();
        arm[0] = 1'b0;
        checks++; if (armed[0] !== 1'b1) begin failures++; $display("FAIL idle_arm_trig_armed got %b expected 1", armed[0]); end
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (glitch[0] || busy[0] || !armed[0]) highs++;
        end
        checks++; if (highs !== 0) begin failures++; $display("FAIL idle_arm_trig_activity got %0d expected 0", highs); end
        trigger = 1'b0;
        idle(SYNC + 2);
    endtask

    initial begin
        rst_n     = 1'b0;
        trigger   = 1'b0;
        abort     = 1'b0;
        arm       = '0;
        cfg_delay = '0;
        cfg_width = '0;
        cfg_gap   = '0;
        cfg_count = '0;
        cfg_pol   = POL;
        test_reset();
        test_single();
        test_burst();
        test_polarity();
        test_retrigger();
        test_arm_vs_trigger();
        test_abort();
        test_async_reset();
        test_arm_trig_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glitch_gen_multi.md
Name: glitch_gen_multi

Overview:
Parametrised multi-channel successor to the single-shot glitch generator. One shared trigger input starts up to NUM_CH independent channels. Each channel has its own runtime-programmable delay, pulse width, pulse count (burst), inter-pulse gap and output polarity, replacing the single compile-time delay and width. Sits in the PLL clock domain between the trigger pin and the glitch output pins; status outputs drive LEDs or host readback.

Parameters:
NUM_CH, 4, number of independent glitch channels (1..8)
CNT_W, 32, width of the delay, width and gap counters, in clk cycles
BURST_W, 8, width of the per-channel pulse-count field
SYNC_STAGES, 2, flip-flop stages in the trigger/abort synchronisers (>=2)

Ports:
clk  in  1  PLL core clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
trigger  in  1  asynchronous external trigger, rising-edge sensitive
arm  in  NUM_CH  synchronous per-channel arm strobe; latches that channel's cfg_* fields
abort  in  1  asynchronous abort; synchronised internally; kills all channels
cfg_delay  in  NUM_CH*CNT_W  per-channel cycles from trigger edge to first pulse
cfg_width  in  NUM_CH*CNT_W  per-channel pulse high time in cycles (0 treated as 1)
cfg_gap  in  NUM_CH*CNT_W  per-channel low time between burst pulses (0 treated as 1)
cfg_count  in  NUM_CH*BURST_W  per-channel pulses per trigger (0 treated as 1)
cfg_pol  in  NUM_CH  per-channel output polarity: 0 = active-high, 1 = active-low
glitch  out  NUM_CH  per-channel registered glitch outputs
armed  out  NUM_CH  channel is waiting for a trigger
busy  out  NUM_CH  channel is in DELAY, PULSE or GAP
done  out  NUM_CH  sticky; burst completed; cleared by the next arm of that channel

Behaviour:
- Reset, asynchronous: all channels go to IDLE. glitch = 0 ^ cfg_pol, driven from registered state (no glitch on reset release). armed, busy and done = 0. Synchronisers clear to 0.
- trigger and abort pass through SYNC_STAGES flops. A one-cycle trig_rise pulse is generated on the synchronised 0->1 transition.
- Per-channel FSM: IDLE, ARMED, DELAY, PULSE, GAP, DONE.
- IDLE/DONE + arm[i]: latch cfg_*[i] into shadow registers, clear done[i], go to ARMED. Cfg inputs are ignored at all other times.
- arm[i] in ARMED: re-latches the config. arm[i] in DELAY, PULSE or GAP: ignored.
- ARMED + trig_rise: load the delay counter and go to DELAY. If delay = 0, go directly to PULSE.
- Timing: let edge k be the first clk edge that samples trigger = 1. The active glitch level then starts exactly SYNC_STAGES+1+delay cycles after edge k. Each pulse lasts exactly width cycles. Each gap between pulses lasts exactly gap cycles. Exactly count pulses are produced.
- PULSE end: if pulses remain, go to GAP; otherwise go to DONE with done = 1.
- DONE: done stays 1 until the next arm. Further triggers are ignored.
- trig_rise while in DELAY, PULSE or GAP: ignored (no retrigger, no restart).
- Simultaneous arm[i] and trig_rise in IDLE: the arm takes effect and the trigger is dropped; the channel ends in ARMED.
- Simultaneous arm[i] and trig_rise in ARMED: the trigger wins using the previously latched config; the arm is dropped.
- Synchronised abort high: every channel goes to IDLE on the next edge. glitch returns to its inactive level on that edge. done is not set. While abort is held, arm is ignored.
- Counters are CNT_W-bit down-counters and never wrap. The maximum delay is 2^CNT_W-1.
- Channels are fully independent apart from sharing trigger and abort.

Decomposition:
- Package glitch_gen_pkg holds: the channel state enum (IDLE, ARMED, DELAY, PULSE, GAP, DONE, encoded in 3 bits), the default widths, and a helper for "0 means 1" field normalisation.
- Sub-module glitch_channel contains one FSM with its shadow config and counters. The top level holds the synchronisers, the edge detector and a generate loop of NUM_CH glitch_channel instances.

Test Plan:
1. Reset then arm ch0 with delay=10, width=3, count=1, pol=0; raise trigger at edge k -> glitch[0] high on cycles k+13..k+15 only; done[0]=1 afterwards; busy[0] high from k+3 to k+15.
2. ch1 with delay=0, width=2, gap=4, count=3 -> three 2-cycle pulses separated by 4 low cycles, first pulse starting k+3; done[1] set after the third pulse.
3. ch2 with cfg_pol=1, width=0 -> glitch[2] idles high and drops low for exactly 1 cycle.
4. Second trigger edge during ch0 DELAY, and another trigger after DONE -> no extra pulses. Re-arm, then trigger -> the pulse repeats and done clears at the arm.
5. Assert abort mid-PULSE of a 100-cycle width -> glitch goes inactive SYNC_STAGES+1 cycles after abort; state IDLE; armed, busy and done all 0.
6. Pull rst_n low mid-burst asynchronously -> all outputs at reset values immediately. Arm and trigger in the same cycle from IDLE -> armed=1 and no pulse.
